scratch_fill_controller: RTL and testbench

- Parametrised successor of the single-word buffer-to-scratchpad read controller.
- On `start`, once the scratchpad grants `scratch_write_en`, moves a burst of BURST_LEN words from the read buffer into consecutive scratchpad addresses. Each word uses a valid handshake.
- Keeps its own wrapping scratchpad write pointer and signals burst completion.
- Sits between the input buffer and the scratchpad in the datapath load stage.

---
 rtl/scratch_fill_controller.sv | 189 ++++++++++++++++++
 tb/tb_scratch_fill_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_fill_controller.sv
// -----------------------------------------------------------------------------
// scratch_fill_controller
//
// Moves a burst of BURST_LEN words from the input read buffer into consecutive
// scratchpad addresses. A burst starts from IDLE when `start` and
// `scratch_write_en` are both high. Each word is fetched with a valid
// handshake (READ_REQ), then written for one cycle (WRITE). After the last
// word, DONE pulses for one cycle and the controller returns to IDLE. The
// write pointer wraps at DEPTH and is kept across bursts, so back-to-back
// bursts fill consecutive addresses.
//
// Optional feature (macro SCRATCH_FILL_TIMEOUT_EN): a READ_REQ wait counter
// abandons the burst after TIMEOUT_CYCLES stalled cycles and sets the sticky
// `timeout_err` output. Without the macro, READ_REQ waits indefinitely and the
// `timeout_err` port does not exist.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   inner_rst          synchronous clear, highest priority
//   start              level request for a new burst
//   scratch_write_en   scratchpad grant
//   valid, buf_data    buffer read handshake and data
//   write_req_scratch  idle, requesting scratchpad grant
//   read_req_buffer    requesting next buffer word
//   write_in_scratch   scratchpad write strobe
//   cnt                one pulse per word written
//   scratch_addr       scratchpad write address
//   scratch_wdata      registered scratchpad write data
//   done               one-cycle pulse after the last word
//   busy               any state other than IDLE
//   timeout_err        sticky timeout flag (optional feature only)
// -----------------------------------------------------------------------------
module scratch_fill_controller #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 16,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inner_rst,
    input  logic              start,
    input  logic              scratch_write_en,
    input  logic              valid,
    input  logic [DATA_W-1:0] buf_data,
    output logic              write_req_scratch,
    output logic              read_req_buffer,
    output logic              write_in_scratch,
    output logic              cnt,
    output logic [ADDR_W-1:0] scratch_addr,
    output logic [DATA_W-1:0] scratch_wdata,
    output logic              done,
    output logic              busy
`ifdef SCRATCH_FILL_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(BURST_LEN - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] READ_REQ = 2'd1;
    localparam logic [1:0] WRITE    = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CNT_W-1:0]  word_q,  word_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef SCRATCH_FILL_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers latches.
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
`ifdef SCRATCH_FILL_TIMEOUT_EN
        wait_d    = '0;            // cleared whenever not stalling in READ_REQ
        timeout_d = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (start && scratch_write_en) begin
                    state_d = READ_REQ;
                end
            end
            READ_REQ: begin
                if (valid) begin
                    wdata_d = buf_data;
                    state_d = WRITE;
                end
`ifdef SCRATCH_FILL_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    // Abandon the burst: no DONE pulse, pointer kept.
                    timeout_d = 1'b1;
                    word_d    = '0;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            WRITE: begin
                addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                if (word_q == WORD_LAST) begin
                    word_d  = '0;
                    state_d = DONE;
                end else begin
                    word_d  = word_q + 1'b1;
                    state_d = READ_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Synchronous clear overrides everything, including a mid-burst state.
        if (inner_rst) begin
            state_d = IDLE;
            addr_d  = '0;
            word_d  = '0;
            wdata_d = '0;
`ifdef SCRATCH_FILL_TIMEOUT_EN
            wait_d    = '0;
            timeout_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values and simulation matches hardware.
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef SCRATCH_FILL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`endif

    // Moore outputs decoded from state only.
    assign write_req_scratch = (state_q == IDLE);
    assign read_req_buffer   = (state_q == READ_REQ);
    assign write_in_scratch  = (state_q == WRITE);
    assign cnt               = (state_q == WRITE);
    assign done              = (state_q == DONE);
    assign busy              = (state_q != IDLE);
    assign scratch_addr      = addr_q;
    assign scratch_wdata     = wdata_q;

endmodule

// File: tb/tb_scratch_fill_controller.sv
// -----------------------------------------------------------------------------
// Self-checking bench for scratch_fill_controller (DEPTH=16, BURST_LEN=4).
// Bursts are described by a table of records; expected writes are pushed to a
// scoreboard queue as each word is offered and popped by a monitor when the
// write strobe appears. Hand-written sequences cover inner_rst mid-burst,
// asynchronous reset mid-WRITE and, when compiled in, the timeout feature.
// -----------------------------------------------------------------------------
module tb_scratch_fill_controller;

    localparam int DATA_W         = 16;
    localparam int DEPTH          = 16;
    localparam int BURST_LEN      = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int ADDR_W         = 4;

    logic              clk;
    logic              rst_n;
    logic              inner_rst;
    logic              start;
    logic              scratch_write_en;
    logic              valid;
    logic [DATA_W-1:0] buf_data;
    logic              write_req_scratch;
    logic              read_req_buffer;
    logic              write_in_scratch;
    logic              cnt;
    logic [ADDR_W-1:0] scratch_addr;
    logic [DATA_W-1:0] scratch_wdata;
    logic              done;
    logic              busy;
`ifdef SCRATCH_FILL_TIMEOUT_EN
    logic              timeout_err;
`endif

    scratch_fill_controller #(
        .DATA_W        (DATA_W),
        .DEPTH         (DEPTH),
        .BURST_LEN     (BURST_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .inner_rst        (inner_rst),
        .start            (start),
        .scratch_write_en (scratch_write_en),
        .valid            (valid),
        .buf_data         (buf_data),
        .write_req_scratch(write_req_scratch),
        .read_req_buffer  (read_req_buffer),
        .write_in_scratch (write_in_scratch),
        .cnt              (cnt),
        .scratch_addr     (scratch_addr),
        .scratch_wdata    (scratch_wdata),
        .done             (done),
        .busy             (busy)
`ifdef SCRATCH_FILL_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One table row per burst: stimulus plus the address the burst must start at.
    typedef struct {
        logic [DATA_W-1:0] base;
        int                stall_idx;
        int                stall_len;
        bit                hold_start;
        logic [ADDR_W-1:0] exp_first;
    } burst_vec_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    wr_exp_t           sb[$];
    int                checks    = 0;
    int                failures  = 0;
    int                done_seen = 0;
    int                exp_done  = 0;
    logic [ADDR_W-1:0] exp_addr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest pending scoreboard entry.
    wr_exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_seen++;
            if (write_in_scratch || cnt) begin
                check("cnt_with_write", {31'd0, cnt}, {31'd0, write_in_scratch});
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_write: write at addr %0d data 0x%0h with nothing pending",
                             scratch_addr, scratch_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", {28'd0, scratch_addr}, {28'd0, mon_e.addr});
                    check("wr_data", {16'd0, scratch_wdata}, {16'd0, mon_e.data});
                end
            end
        end
    end

    task automatic offer_word(input logic [DATA_W-1:0] data);
        wr_exp_t e;
        valid    = 1'b1;
        buf_data = data;
        e.addr   = exp_addr;
        e.data   = data;
        sb.push_back(e);
        exp_addr = exp_addr + 1'b1;
    endtask

    // Entered and left in IDLE, one time unit after a rising edge.
    task automatic do_burst(input burst_vec_t v);
        int n;
        check("idle_before", {31'd0, write_req_scratch}, 32'd1);
        start            = 1'b1;
        scratch_write_en = 1'b1;
        step();
        if (!v.hold_start) begin
            start            = 1'b0;
            scratch_write_en = 1'b0;
        end
        check("enter_rreq", {31'd0, read_req_buffer}, 32'd1);
        check("first_addr", {28'd0, scratch_addr}, {28'd0, v.exp_first});
        for (int i = 0; i < BURST_LEN; i++) begin
            n = (i == v.stall_idx) ? v.stall_len : 0;
            for (int s = 0; s < n; s++) begin
                valid    = 1'b0;
                buf_data = 16'hDEAD;
                step();
                check("stall_rreq", {31'd0, read_req_buffer}, 32'd1);
                check("stall_no_write", {31'd0, write_in_scratch}, 32'd0);
            end
            offer_word(v.base + DATA_W'(i));
            step();
            check("write_strobe", {31'd0, write_in_scratch}, 32'd1);
            valid    = 1'b0;
            buf_data = 16'hDEAD;
            step();
            if (i == BURST_LEN - 1) check("done_pulse", {31'd0, done}, 32'd1);
            else                    check("next_rreq", {31'd0, read_req_buffer}, 32'd1);
        end
        step();
        check("idle_after_done", {31'd0, write_req_scratch}, 32'd1);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        start            = 1'b0;
        scratch_write_en = 1'b0;
        exp_done++;
    endtask

    burst_vec_t vecs[5];
    burst_vec_t v;

    initial begin
        // Five bursts: the first four cover addresses 0..15, the fifth wraps to 0.
        vecs[0] = '{base: 16'h00A0, stall_idx: -1, stall_len: 0, hold_start: 1'b1, exp_first: 4'd0};
        vecs[1] = '{base: 16'h00B0, stall_idx:  1, stall_len: 5, hold_start: 1'b0, exp_first: 4'd4};
        vecs[2] = '{base: 16'h00C0, stall_idx:  0, stall_len: 2, hold_start: 1'b1, exp_first: 4'd8};
        vecs[3] = '{base: 16'h00D0, stall_idx:  3, stall_len: 1, hold_start: 1'b0, exp_first: 4'd12};
        vecs[4] = '{base: 16'h00E0, stall_idx: -1, stall_len: 0, hold_start: 1'b1, exp_first: 4'd0};

        rst_n            = 1'b0;
        inner_rst        = 1'b0;
        start            = 1'b0;
        scratch_write_en = 1'b0;
        valid            = 1'b0;
        buf_data         = '0;
        #12;
        check("rst_write_req", {31'd0, write_req_scratch}, 32'd1);
        check("rst_read_req", {31'd0, read_req_buffer}, 32'd0);
        check("rst_write_in", {31'd0, write_in_scratch}, 32'd0);
        check("rst_cnt", {31'd0, cnt}, 32'd0);
        check("rst_addr", {28'd0, scratch_addr}, 32'd0);
        check("rst_wdata", {16'd0, scratch_wdata}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SCRATCH_FILL_TIMEOUT_EN
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // valid is ignored in IDLE; any write here would hit an empty scoreboard.
        valid    = 1'b1;
        buf_data = 16'hBAD0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ignores_valid", {31'd0, write_req_scratch}, 32'd1);
        end
        valid = 1'b0;

        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            do_burst(v);
        end

        // inner_rst while waiting for the third word (valid also high, must lose).
        start            = 1'b1;
        scratch_write_en = 1'b1;
        step();
        start            = 1'b0;
        scratch_write_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer_word(16'h5510 + DATA_W'(i));
            step();
            check("irst_write_strobe", {31'd0, write_in_scratch}, 32'd1);
            valid = 1'b0;
            step();
        end
        check("irst_in_rreq", {31'd0, read_req_buffer}, 32'd1);
        inner_rst = 1'b1;
        valid     = 1'b1;
        buf_data  = 16'h55FF;
        step();
        inner_rst = 1'b0;
        valid     = 1'b0;
        check("irst_idle", {31'd0, write_req_scratch}, 32'd1);
        check("irst_busy", {31'd0, busy}, 32'd0);
        check("irst_addr", {28'd0, scratch_addr}, 32'd0);
        check("irst_wdata", {16'd0, scratch_wdata}, 32'd0);
        step();
        check("irst_no_done", {31'd0, done}, 32'd0);
        exp_addr = '0;
        v = '{base: 16'h6600, stall_idx: -1, stall_len: 0, hold_start: 1'b0, exp_first: 4'd0};
        do_burst(v);

        // Asynchronous reset between edges while in WRITE.
        start            = 1'b1;
        scratch_write_en = 1'b1;
        step();
        start            = 1'b0;
        scratch_write_en = 1'b0;
        offer_word(16'h7700);
        step();
        valid = 1'b0;
        check("arst_pre_write", {31'd0, write_in_scratch}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_write_req", {31'd0, write_req_scratch}, 32'd1);
        check("arst_addr", {28'd0, scratch_addr}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_write_in", {31'd0, write_in_scratch}, 32'd0);
        sb.delete();
        exp_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        v = '{base: 16'h8800, stall_idx: 1, stall_len: 3, hold_start: 1'b1, exp_first: 4'd0};
        do_burst(v);

`ifdef SCRATCH_FILL_TIMEOUT_EN
        // Stall forever: abandon after TIMEOUT_CYCLES, sticky until inner_rst.
        check("to_clear_before", {31'd0, timeout_err}, 32'd0);
        start            = 1'b1;
        scratch_write_en = 1'b1;
        step();
        start            = 1'b0;
        scratch_write_en = 1'b0;
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step();
        check("to_still_waiting", {31'd0, read_req_buffer}, 32'd1);
        check("to_not_yet", {31'd0, timeout_err}, 32'd0);
        step();
        check("to_set", {31'd0, timeout_err}, 32'd1);
        check("to_idle", {31'd0, write_req_scratch}, 32'd1);
        check("to_addr_kept", {28'd0, scratch_addr}, {28'd0, exp_addr});
        for (int i = 0; i < 3; i++) step();
        check("to_sticky", {31'd0, timeout_err}, 32'd1);
        inner_rst = 1'b1;
        step();
        inner_rst = 1'b0;
        check("to_cleared", {31'd0, timeout_err}, 32'd0);
`endif

        step();
        check("done_count", done_seen, exp_done);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
